// File: rtl/coco_dma_pkg.sv
// coco_dma_pkg: shared constants for the multi-channel CoCo cartridge DMA.
//   - register window offsets (relative to REG_BASE)
//   - knock byte values
//   - FSM state encoding
//   - CTRL register bit positions
package coco_dma_pkg;

  localparam logic [3:0] OFF_CHSEL  = 4'd0;
  localparam logic [3:0] OFF_MEM_E  = 4'd1;
  localparam logic [3:0] OFF_MEM_H  = 4'd2;
  localparam logic [3:0] OFF_MEM_L  = 4'd3;
  localparam logic [3:0] OFF_SYS_H  = 4'd4;
  localparam logic [3:0] OFF_SYS_L  = 4'd5;
  localparam logic [3:0] OFF_LEN_H  = 4'd6;
  localparam logic [3:0] OFF_LEN_L  = 4'd7;
  localparam logic [3:0] OFF_CTRL   = 4'd8;
  localparam logic [3:0] OFF_STATUS = 4'd9;
  localparam logic [3:0] OFF_KNOCK1 = 4'd10;
  localparam logic [3:0] OFF_KNOCK2 = 4'd11;

  localparam logic [7:0] KNOCK1_VAL = 8'hA5;
  localparam logic [7:0] KNOCK2_VAL = 8'h5A;

  localparam int CTRL_DIR      = 0;
  localparam int CTRL_MEM_HOLD = 1;
  localparam int CTRL_SYS_HOLD = 2;
  localparam int CTRL_IRQ_EN   = 6;
  localparam int CTRL_ENABLE   = 7;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    SETTLE,
    XFER,
    DONE
  } dma_state_e;

endpackage

// File: rtl/coco_dma_channel.sv
// coco_dma_channel: one DMA descriptor (MEM / SYS / LEN / CTRL) plus its done flag.
// Ports:
//   e_cpu, _reset_cpu   falling-edge clock, synchronous active-low reset
//   reg_off, wr_data    register offset and write data from the CPU bus
//   wr_en               write strobe, already qualified by channel select
//   status_clr          write-1-clear of this channel's done bit
//   run_start           edge that leaves SETTLE; enabled empty channels finish here
//   active              this channel moves one byte at this edge
//   rd_data             readback for offsets 1-8
//   mem_addr, sys_addr  current SRAM / CoCo addresses
//   dir, done, ready, last, fin_irq  status toward the top-level arbiter
module coco_dma_channel
  import coco_dma_pkg::*;
#(
  parameter int MEM_AW = 19,
  parameter int LEN_W  = 16
) (
  input  logic              e_cpu,
  input  logic              _reset_cpu,
  input  logic [3:0]        reg_off,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  input  logic              status_clr,
  input  logic              run_start,
  input  logic              active,
  output logic [7:0]        rd_data,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [15:0]       sys_addr,
  output logic              dir,
  output logic              done,
  output logic              ready,
  output logic              last,
  output logic              fin_irq
);

  logic [LEN_W-1:0] len;
  logic [7:0]       ctrl;
  logic [23:0]      mem_ext;
  logic [15:0]      len_ext;
  logic             empty;
  logic             finishing;

  assign mem_ext = 24'(mem_addr);
  assign len_ext = 16'(len);
  assign empty   = (len == '0);
  assign ready   = ctrl[CTRL_ENABLE] && !empty;
  assign last    = (len == LEN_W'(1));
  assign dir     = ctrl[CTRL_DIR];

  // An enabled channel with nothing to move is retired at run start.
  assign finishing = (active && last) || (run_start && ctrl[CTRL_ENABLE] && empty);
  assign fin_irq   = finishing && ctrl[CTRL_IRQ_EN];

  always_ff @(negedge e_cpu) begin
    if (!_reset_cpu) begin
      mem_addr <= '0;
      sys_addr <= '0;
      len      <= '0;
      ctrl     <= '0;
      done     <= 1'b0;
    end else begin
      if (wr_en) begin
        case (reg_off)
          OFF_MEM_E: mem_addr <= MEM_AW'({wr_data, mem_ext[15:0]});
          OFF_MEM_H: mem_addr <= MEM_AW'({mem_ext[23:16], wr_data, mem_ext[7:0]});
          OFF_MEM_L: mem_addr <= MEM_AW'({mem_ext[23:8], wr_data});
          OFF_SYS_H: sys_addr <= {wr_data, sys_addr[7:0]};
          OFF_SYS_L: sys_addr <= {sys_addr[15:8], wr_data};
          OFF_LEN_H: len      <= LEN_W'({wr_data, len_ext[7:0]});
          OFF_LEN_L: len      <= LEN_W'({len_ext[15:8], wr_data});
          OFF_CTRL:  ctrl     <= wr_data;
          default:   ;
        endcase
      end
      if (active) begin
        len <= len - LEN_W'(1);
        if (!ctrl[CTRL_MEM_HOLD]) mem_addr <= mem_addr + MEM_AW'(1);
        if (!ctrl[CTRL_SYS_HOLD]) sys_addr <= sys_addr + 16'd1;
      end
      if (finishing) ctrl[CTRL_ENABLE] <= 1'b0;
      // hardware set beats a simultaneous write-1-clear
      if (finishing)       done <= 1'b1;
      else if (status_clr) done <= 1'b0;
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_off)
      OFF_MEM_E: rd_data = mem_ext[23:16];
      OFF_MEM_H: rd_data = mem_ext[15:8];
      OFF_MEM_L: rd_data = mem_ext[7:0];
      OFF_SYS_H: rd_data = sys_addr[15:8];
      OFF_SYS_L: rd_data = sys_addr[7:0];
      OFF_LEN_H: rd_data = len_ext[15:8];
      OFF_LEN_L: rd_data = len_ext[7:0];
      OFF_CTRL:  rd_data = ctrl;
      default:   rd_data = '0;
    endcase
  end

endmodule

// File: rtl/coco_dma_mc.sv
// coco_dma_mc: multi-channel DMA between the CoCo cartridge bus and on-board SRAM.
// A knock sequence ($A5 to KNOCK1, then $5A to KNOCK2) halts the 6809; enabled
// channels then run back-to-back, lowest index first, one byte per E cycle.
// Ports:
//   e_cpu, _reset_cpu          falling-edge clock, synchronous active-low reset
//   r_w_cpu, address_cpu       CPU bus, driven by this block only in XFER
//   data_cpu                   CPU data (register reads, SRAM->CoCo bytes)
//   _halt, _nmi                open-drain, 0 or z
//   address_mem, data_mem      SRAM address / data
//   _we_mem, _ce_ram           SRAM strobes, active low
//   led                        high while transferring
//
// state  | meaning
// IDLE   | CPU owns the bus, registers writable, waiting for KNOCK1
// ARMED  | KNOCK1 seen; next CPU write must be KNOCK2
// SETTLE | _halt asserted, waiting HALT_SETTLE E cycles
// XFER   | moving one byte per E cycle for channel cur
// DONE   | _halt released, optional one-cycle _nmi
module coco_dma_mc
  import coco_dma_pkg::*;
#(
  parameter int          CHANNELS    = 2,
  parameter int          MEM_AW      = 19,
  parameter int          LEN_W       = 16,
  parameter logic [11:0] REG_BASE    = 12'hff6,
  parameter int          HALT_SETTLE = 2
) (
  input  logic              e_cpu,
  input  logic              _reset_cpu,
  inout  logic              r_w_cpu,
  inout  logic [15:0]       address_cpu,
  inout  logic [7:0]        data_cpu,
  output logic              _halt,
  output logic              _nmi,
  output logic [MEM_AW-1:0] address_mem,
  inout  logic [7:0]        data_mem,
  output logic              _we_mem,
  output logic              _ce_ram,
  output logic              led
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SW = $clog2(HALT_SETTLE + 2);

  dma_state_e state, state_nx;
  logic [CW-1:0] cur, chsel, pick;
  logic [SW-1:0] settle_cnt;
  logic          irq_pend, pick_ok, settle_exit;
  logic          halt_on, bus_own, nmi_on;

  logic [3:0] reg_off;
  logic       win_hit, bus_wr, reg_wr, rd_drv;
  logic [7:0] rd_data;

  logic [MEM_AW-1:0]   ch_mem [CHANNELS];
  logic [15:0]         ch_sys [CHANNELS];
  logic [7:0]          ch_rd  [CHANNELS];
  logic [CHANNELS-1:0] ch_dir, ch_done, ch_ready, ch_last, ch_fin_irq, avail;

  assign reg_off     = address_cpu[3:0];
  assign win_hit     = (address_cpu[15:4] == REG_BASE);
  assign bus_wr      = !r_w_cpu;
  assign reg_wr      = bus_wr && win_hit && (state == IDLE || state == ARMED);
  assign settle_exit = (state == SETTLE) && (settle_cnt <= SW'(1));

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    coco_dma_channel #(
      .MEM_AW (MEM_AW),
      .LEN_W  (LEN_W)
    ) u_ch (
      .e_cpu      (e_cpu),
      ._reset_cpu (_reset_cpu),
      .reg_off    (reg_off),
      .wr_data    (data_cpu),
      .wr_en      (reg_wr && chsel == CW'(i)),
      .status_clr (reg_wr && reg_off == OFF_STATUS && data_cpu[i]),
      .run_start  (settle_exit),
      .active     (state == XFER && cur == CW'(i)),
      .rd_data    (ch_rd[i]),
      .mem_addr   (ch_mem[i]),
      .sys_addr   (ch_sys[i]),
      .dir        (ch_dir[i]),
      .done       (ch_done[i]),
      .ready      (ch_ready[i]),
      .last       (ch_last[i]),
      .fin_irq    (ch_fin_irq[i])
    );
  end

  // The channel finishing at this edge is no longer a candidate for the next byte.
  always_comb begin
    avail = ch_ready;
    if (state == XFER && ch_last[cur]) avail[cur] = 1'b0;
  end

  // Priority encoder: scan downward so the lowest index wins.
  always_comb begin
    pick_ok = 1'b0;
    pick    = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (avail[i]) begin
        pick_ok = 1'b1;
        pick    = CW'(i);
      end
    end
  end

  always_ff @(negedge e_cpu) begin
    if (!_reset_cpu) state <= IDLE;
    else             state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:
        if (reg_wr && reg_off == OFF_KNOCK1 && data_cpu == KNOCK1_VAL) state_nx = ARMED;
      ARMED:
        if (bus_wr)
          state_nx = (win_hit && reg_off == OFF_KNOCK2 && data_cpu == KNOCK2_VAL) ? SETTLE : IDLE;
      SETTLE:
        if (settle_exit) state_nx = pick_ok ? XFER : DONE;
      XFER:
        if (ch_last[cur] && !pick_ok) state_nx = DONE;
      DONE:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_comb begin
    halt_on = 1'b0;
    bus_own = 1'b0;
    nmi_on  = 1'b0;
    case (state)
      SETTLE: halt_on = 1'b1;
      XFER: begin
        halt_on = 1'b1;
        bus_own = 1'b1;
      end
      DONE:    nmi_on = irq_pend;
      default: ;
    endcase
  end

  always_ff @(negedge e_cpu) begin
    if (!_reset_cpu) begin
      cur        <= '0;
      chsel      <= '0;
      settle_cnt <= '0;
      irq_pend   <= 1'b0;
    end else begin
      if (reg_wr && reg_off == OFF_CHSEL && data_cpu < 8'(CHANNELS))
        chsel <= data_cpu[CW-1:0];
      if (state == ARMED && state_nx == SETTLE)
        settle_cnt <= SW'(HALT_SETTLE);
      else if (state == SETTLE && settle_cnt != '0)
        settle_cnt <= settle_cnt - SW'(1);
      if ((settle_exit || (state == XFER && ch_last[cur])) && pick_ok)
        cur <= pick;
      if (state == DONE)    irq_pend <= 1'b0;
      else if (|ch_fin_irq) irq_pend <= 1'b1;
    end
  end

  always_comb begin
    rd_data = ch_rd[chsel];
    if (reg_off == OFF_CHSEL)  rd_data = 8'(chsel);
    if (reg_off == OFF_STATUS) rd_data = 8'(ch_done);
  end

  assign rd_drv = e_cpu && r_w_cpu && win_hit && (reg_off <= OFF_STATUS) && (state != XFER);

  assign led         = bus_own;
  assign address_mem = ch_mem[cur];
  assign _ce_ram     = !(bus_own && e_cpu);
  assign _we_mem     = !(bus_own && e_cpu && ch_dir[cur]);
  assign _halt       = halt_on ? 1'b0 : 1'bz;
  assign _nmi        = nmi_on ? 1'b0 : 1'bz;
  assign r_w_cpu     = bus_own ? ch_dir[cur] : 1'bz;
  assign address_cpu = bus_own ? ch_sys[cur] : 16'bz;
  assign data_mem    = (bus_own && e_cpu && ch_dir[cur]) ? data_cpu : 8'bz;
  assign data_cpu    = (bus_own && e_cpu && !ch_dir[cur]) ? data_mem :
                       rd_drv ? rd_data : 8'bz;

endmodule

// File: tb/tb_coco_dma_mc.sv
// Directed bench for coco_dma_mc. Open-drain and released bus lines are pulled
// high, so "released" reads back as all ones. SRAM returns addr[7:0]+$11 and
// CoCo-side reads return addr[7:0]^$3C.
module tb_coco_dma_mc;

  logic e_cpu = 1'b0;
  logic _reset_cpu;

  tri1        r_w_cpu;
  tri1 [15:0] address_cpu;
  tri1 [7:0]  data_cpu;
  tri1        _halt;
  tri1        _nmi;
  tri1 [7:0]  data_mem;
  wire [18:0] address_mem;
  wire        _we_mem, _ce_ram, led;

  logic        cpu_drv, cpu_rw;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        per_drv;

  int n_tests = 0;
  int n_fail  = 0;

  coco_dma_mc dut (
    .e_cpu       (e_cpu),
    ._reset_cpu  (_reset_cpu),
    .r_w_cpu     (r_w_cpu),
    .address_cpu (address_cpu),
    .data_cpu    (data_cpu),
    ._halt       (_halt),
    ._nmi        (_nmi),
    .address_mem (address_mem),
    .data_mem    (data_mem),
    ._we_mem     (_we_mem),
    ._ce_ram     (_ce_ram),
    .led         (led)
  );

  always #10 e_cpu = ~e_cpu;

  assign per_drv     = led && r_w_cpu && e_cpu;
  assign r_w_cpu     = cpu_drv ? cpu_rw : 1'bz;
  assign address_cpu = cpu_drv ? cpu_addr : 16'bz;
  assign data_cpu    = (cpu_drv && !cpu_rw) ? cpu_data :
                       per_drv ? (address_cpu[7:0] ^ 8'h3C) : 8'bz;
  assign data_mem    = (!_ce_ram && _we_mem) ? (address_mem[7:0] + 8'h11) : 8'bz;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge e_cpu);
    #1;
  endtask

  task automatic sample();
    @(posedge e_cpu);
    #5;
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    cpu_drv = 1'b1; cpu_rw = 1'b0; cpu_addr = a; cpu_data = d;
    tick();
    cpu_drv = 1'b0;
  endtask

  task automatic cpu_rd(input logic [15:0] a, output logic [7:0] d);
    cpu_drv = 1'b1; cpu_rw = 1'b1; cpu_addr = a;
    sample();
    d = data_cpu;
    tick();
    cpu_drv = 1'b0;
  endtask

  task automatic reg_wr(input logic [3:0] off, input logic [7:0] d);
    cpu_wr({12'hff6, off}, d);
  endtask

  task automatic reg_chk(input string tag, input logic [3:0] off, input logic [7:0] exp);
    logic [7:0] d;
    cpu_rd({12'hff6, off}, d);
    check_eq(tag, 32'(d), 32'(exp));
  endtask

  task automatic prog(input logic [7:0] ch, input logic [23:0] mem, input logic [15:0] sys,
                      input logic [15:0] len, input logic [7:0] ctrl);
    reg_wr(4'd0, ch);
    reg_wr(4'd1, mem[23:16]);
    reg_wr(4'd2, mem[15:8]);
    reg_wr(4'd3, mem[7:0]);
    reg_wr(4'd4, sys[15:8]);
    reg_wr(4'd5, sys[7:0]);
    reg_wr(4'd6, len[15:8]);
    reg_wr(4'd7, len[7:0]);
    reg_wr(4'd8, ctrl);
  endtask

  task automatic knock();
    reg_wr(4'd10, 8'hA5);
    reg_wr(4'd11, 8'h5A);
  endtask

  // One DMA byte cycle: check bus contents mid E-high, then step past its edge.
  task automatic chk_byte(input string tag, input logic [15:0] sys, input logic [18:0] mem,
                          input logic dir);
    logic [7:0] exp_d;
    sample();
    check_eq({tag, " led"}, 32'(led), 32'd1);
    check_eq({tag, " halt"}, 32'(_halt), 32'd0);
    check_eq({tag, " addr_cpu"}, 32'(address_cpu), 32'(sys));
    check_eq({tag, " addr_mem"}, 32'(address_mem), 32'(mem));
    check_eq({tag, " r_w"}, 32'(r_w_cpu), 32'(dir));
    check_eq({tag, " ce"}, 32'(_ce_ram), 32'd0);
    check_eq({tag, " we"}, 32'(_we_mem), 32'(!dir));
    if (dir) begin
      exp_d = sys[7:0] ^ 8'h3C;
      check_eq({tag, " data_mem"}, 32'(data_mem), 32'(exp_d));
    end else begin
      exp_d = mem[7:0] + 8'h11;
      check_eq({tag, " data_cpu"}, 32'(data_cpu), 32'(exp_d));
    end
    tick();
  endtask

  task automatic chk_done_cycle(input string tag, input logic exp_nmi);
    sample();
    check_eq({tag, " done halt"}, 32'(_halt), 32'd1);
    check_eq({tag, " done led"}, 32'(led), 32'd0);
    check_eq({tag, " done nmi"}, 32'(_nmi), 32'(exp_nmi));
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cpu_drv = 1'b0; cpu_rw = 1'b1; cpu_addr = '0; cpu_data = '0;
    _reset_cpu = 1'b0;

    // reset state
    tick(); tick();
    sample();
    check_eq("rst halt", 32'(_halt), 32'd1);
    check_eq("rst nmi", 32'(_nmi), 32'd1);
    check_eq("rst ce", 32'(_ce_ram), 32'd1);
    check_eq("rst we", 32'(_we_mem), 32'd1);
    check_eq("rst led", 32'(led), 32'd0);
    check_eq("rst addr_cpu", 32'(address_cpu), 32'hFFFF);
    check_eq("rst r_w", 32'(r_w_cpu), 32'd1);
    check_eq("rst data_mem", 32'(data_mem), 32'hFF);
    tick();
    _reset_cpu = 1'b1;
    reg_chk("rst chsel", 4'd0, 8'h00);
    reg_chk("rst status", 4'd9, 8'h00);
    reg_chk("rst len_l", 4'd7, 8'h00);
    reg_chk("rst mem_e", 4'd1, 8'h00);
    reg_chk("rst knock read", 4'd10, 8'hFF);

    // CHSEL out of range is ignored
    reg_wr(4'd0, 8'h01);
    reg_wr(4'd0, 8'h03);
    reg_wr(4'd0, 8'h02);
    reg_chk("chsel range", 4'd0, 8'h01);

    // single channel SRAM->CoCo, 3 bytes
    prog(8'd0, 24'h000100, 16'h0400, 16'd3, 8'h80);
    reg_chk("t1 ctrl rd", 4'd8, 8'h80);
    knock();
    sample();
    check_eq("t1 settle halt", 32'(_halt), 32'd0);
    check_eq("t1 settle led0", 32'(led), 32'd0);
    tick();
    sample();
    check_eq("t1 settle led1", 32'(led), 32'd0);
    tick();
    chk_byte("t1 b0", 16'h0400, 19'h00100, 1'b0);
    chk_byte("t1 b1", 16'h0401, 19'h00101, 1'b0);
    chk_byte("t1 b2", 16'h0402, 19'h00102, 1'b0);
    chk_done_cycle("t1", 1'b1);
    reg_chk("t1 status", 4'd9, 8'h01);
    reg_chk("t1 ctrl", 4'd8, 8'h00);
    reg_chk("t1 len_l", 4'd7, 8'h00);
    reg_chk("t1 mem_l", 4'd3, 8'h03);
    reg_chk("t1 sys_l", 4'd5, 8'h03);

    // two channels back-to-back, mixed directions
    reg_wr(4'd9, 8'hFF);
    reg_chk("t2 status clr", 4'd9, 8'h00);
    prog(8'd0, 24'h000200, 16'h0500, 16'd2, 8'h81);
    prog(8'd1, 24'h000300, 16'h0600, 16'd1, 8'h80);
    knock();
    tick(); tick();
    chk_byte("t2 c0b0", 16'h0500, 19'h00200, 1'b1);
    chk_byte("t2 c0b1", 16'h0501, 19'h00201, 1'b1);
    chk_byte("t2 c1b0", 16'h0600, 19'h00300, 1'b0);
    chk_done_cycle("t2", 1'b1);
    reg_chk("t2 status", 4'd9, 8'h03);

    // broken knock: intervening write aborts
    reg_wr(4'd9, 8'hFF);
    reg_wr(4'd10, 8'hA5);
    cpu_wr(16'hFF60, 8'h00);
    reg_wr(4'd11, 8'h5A);
    for (int i = 0; i < 4; i++) begin
      sample();
      check_eq("t3 no halt", 32'(_halt), 32'd1);
      check_eq("t3 no led", 32'(led), 32'd0);
      tick();
    end
    reg_chk("t3 status", 4'd9, 8'h00);

    // MEM wrap at 2^19, SYS wrap at 2^16 with mem_hold
    prog(8'd0, 24'hFFFFFF, 16'h0700, 16'd2, 8'h80);
    reg_chk("t4 mem_e", 4'd1, 8'h07);
    prog(8'd1, 24'h000040, 16'hFFFF, 16'd2, 8'h82);
    knock();
    tick(); tick();
    chk_byte("t4 c0b0", 16'h0700, 19'h7FFFF, 1'b0);
    chk_byte("t4 c0b1", 16'h0701, 19'h00000, 1'b0);
    chk_byte("t4 c1b0", 16'hFFFF, 19'h00040, 1'b0);
    chk_byte("t4 c1b1", 16'h0000, 19'h00040, 1'b0);
    chk_done_cycle("t4", 1'b1);
    reg_chk("t4 status", 4'd9, 8'h03);

    // sys_hold keeps address_cpu constant
    reg_wr(4'd9, 8'hFF);
    prog(8'd0, 24'h000010, 16'h0800, 16'd3, 8'h84);
    knock();
    tick(); tick();
    chk_byte("t5 b0", 16'h0800, 19'h00010, 1'b0);
    chk_byte("t5 b1", 16'h0800, 19'h00011, 1'b0);
    chk_byte("t5 b2", 16'h0800, 19'h00012, 1'b0);
    chk_done_cycle("t5", 1'b1);
    reg_chk("t5 sys_h", 4'd4, 8'h08);
    reg_chk("t5 sys_l", 4'd5, 8'h00);
    reg_chk("t5 mem_l", 4'd3, 8'h13);

    // empty enabled channel with irq: no bus cycles, one-cycle _nmi
    reg_wr(4'd9, 8'hFF);
    reg_chk("t6 status clr", 4'd9, 8'h00);
    prog(8'd0, 24'h000050, 16'h0A00, 16'd0, 8'hC0);
    knock();
    for (int i = 0; i < 2; i++) begin
      sample();
      check_eq("t6 settle halt", 32'(_halt), 32'd0);
      check_eq("t6 settle ce", 32'(_ce_ram), 32'd1);
      check_eq("t6 settle nmi", 32'(_nmi), 32'd1);
      tick();
    end
    sample();
    check_eq("t6 done ce", 32'(_ce_ram), 32'd1);
    check_eq("t6 done led", 32'(led), 32'd0);
    check_eq("t6 done halt", 32'(_halt), 32'd1);
    check_eq("t6 nmi pulse", 32'(_nmi), 32'd0);
    tick();
    sample();
    check_eq("t6 nmi after", 32'(_nmi), 32'd1);
    tick();
    reg_chk("t6 status", 4'd9, 8'h01);
    reg_chk("t6 ctrl", 4'd8, 8'h40);

    // reset in the middle of a 5-byte transfer
    reg_wr(4'd9, 8'hFF);
    prog(8'd0, 24'h000400, 16'h0900, 16'd5, 8'h80);
    knock();
    tick(); tick();
    chk_byte("t7 b0", 16'h0900, 19'h00400, 1'b0);
    _reset_cpu = 1'b0;
    sample();
    check_eq("t7 pre-rst led", 32'(led), 32'd1);
    tick();
    sample();
    check_eq("t7 rst addr_cpu", 32'(address_cpu), 32'hFFFF);
    check_eq("t7 rst r_w", 32'(r_w_cpu), 32'd1);
    check_eq("t7 rst led", 32'(led), 32'd0);
    check_eq("t7 rst halt", 32'(_halt), 32'd1);
    check_eq("t7 rst ce", 32'(_ce_ram), 32'd1);
    check_eq("t7 rst data_mem", 32'(data_mem), 32'hFF);
    _reset_cpu = 1'b1;
    tick();
    reg_chk("t7 len_l", 4'd7, 8'h00);
    reg_chk("t7 len_h", 4'd6, 8'h00);
    reg_chk("t7 status", 4'd9, 8'h00);
    reg_chk("t7 ctrl", 4'd8, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
